pool_ctrl: RTL and testbench

- Sequencer for the max-pooling datapath (2x2 window, stride 2).
- Walks an IMG_H x IMG_W feature map held in an input SRAM and streams each 2x2 window into the pooling unit (pool_en / pool_data).
- Writes each window maximum to an output SRAM.
- Sits between the layer controller (start/done handshake) and the pooling unit plus its SRAMs.

---
 rtl/pool_ctrl.sv | 157 +++++++++++++++
 tb/tb_pool_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
// Max-pool (2x2, stride 2) sequencer: streams windows from input SRAM to the pooling unit, writes maxima out.
// Optional abort input / aborted pulse enabled by defining POOL_CTRL_ABORT_EN.
module pool_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] out_base,
`ifdef POOL_CTRL_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              pool_en,
   output logic [DATA_W-1:0] pool_data,
   input  logic [DATA_W-1:0] pool_result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [1:0]        dbg_state
);

   localparam int WX = IMG_W / 2;
   localparam int WY = IMG_H / 2;
   localparam int N  = WX * WY;
   localparam int CW = (WX > 1) ? $clog2(WX) : 1;
   localparam int NW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

   state_t            state;
   logic [2:0]        phase;
   logic [CW-1:0]     col;
   logic [NW-1:0]     widx;
   logic [ADDR_W-1:0] win_addr;
   logic [ADDR_W-1:0] out_b;

   logic [2:0]        np;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] next_win;
   logic              last_col;
   logic              last_win;
   logic              kill;

   assign pool_data = rd_data;
   assign wr_data   = pool_result;
   assign dbg_state = state;

   // Element k of the current window sits at win_addr + k[1]*IMG_W + k[0].
   always_comb begin
      np        = phase + 3'd1;
      next_addr = win_addr + (np[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(np[0]);
      last_col  = (col == CW'(WX - 1));
      last_win  = (widx == NW'(N - 1));
      next_win  = last_col ? win_addr + ADDR_W'(IMG_W + 2) : win_addr + ADDR_W'(2);
`ifdef POOL_CTRL_ABORT_EN
      kill      = abort && (state == RUN || state == FLUSH);
`else
      kill      = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= '0;
         col      <= '0;
         widx     <= '0;
         win_addr <= '0;
         out_b    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         pool_en  <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
`ifdef POOL_CTRL_ABORT_EN
         aborted  <= 1'b0;
`endif
      end else if (kill) begin
         state   <= IDLE;
         busy    <= 1'b0;
         rd_en   <= 1'b0;
         pool_en <= 1'b0;
         wr_en   <= 1'b0;
`ifdef POOL_CTRL_ABORT_EN
         aborted <= 1'b1;
`endif
      end else begin
`ifdef POOL_CTRL_ABORT_EN
         aborted <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  phase    <= '0;
                  col      <= '0;
                  widx     <= '0;
                  win_addr <= in_base;
                  out_b    <= out_base;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  rd_addr  <= in_base;
                  pool_en  <= 1'b0;
               end
            end
            RUN: begin
               if (phase != 3'd4) begin
                  phase   <= np;
                  rd_en   <= (phase != 3'd3);
                  rd_addr <= next_addr;
                  pool_en <= 1'b1;
                  wr_en   <= 1'b0;
               end else begin
                  // Phase 0 of the next window (or FLUSH) writes the window just accumulated.
                  phase   <= '0;
                  wr_en   <= 1'b1;
                  wr_addr <= out_b + ADDR_W'(widx);
                  pool_en <= 1'b0;
                  if (last_win) begin
                     state <= FLUSH;
                     rd_en <= 1'b0;
                  end else begin
                     widx     <= widx + NW'(1);
                     col      <= last_col ? '0 : col + CW'(1);
                     win_addr <= next_win;
                     rd_en    <= 1'b1;
                     rd_addr  <= next_win;
                  end
               end
            end
            FLUSH: begin
               state <= FIN;
               wr_en <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: 4x4 instance (a) and 8x8 instance (b) sharing one input SRAM model.
module tb_pool_ctrl;
   localparam int DW = 32;
   localparam int AW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   int   cyc = 0;
   int   s_cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:4095];

   logic          a_start = 1'b0, b_start = 1'b0;
   logic [AW-1:0] a_in_base = '0, a_out_base = '0, b_in_base = '0, b_out_base = '0;
   logic          a_busy, a_done, a_rd_en, a_pool_en, a_wr_en;
   logic          b_busy, b_done, b_rd_en, b_pool_en, b_wr_en;
   logic [AW-1:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;
   logic [DW-1:0] a_rd_data = '0, a_pool_result = '0, a_pool_data, a_wr_data;
   logic [DW-1:0] b_rd_data = '0, b_pool_result = '0, b_pool_data, b_wr_data;
   logic [1:0]    a_dbg, b_dbg;
`ifdef POOL_CTRL_ABORT_EN
   logic          a_abort = 1'b0, b_abort = 1'b0;
   logic          a_aborted, b_aborted;
`endif

   pool_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(4), .IMG_H(4)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .in_base(a_in_base), .out_base(a_out_base),
`ifdef POOL_CTRL_ABORT_EN
      .abort(a_abort), .aborted(a_aborted),
`endif
      .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
      .pool_en(a_pool_en), .pool_data(a_pool_data), .pool_result(a_pool_result),
      .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .dbg_state(a_dbg)
   );

   pool_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(8), .IMG_H(8)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .in_base(b_in_base), .out_base(b_out_base),
`ifdef POOL_CTRL_ABORT_EN
      .abort(b_abort), .aborted(b_aborted),
`endif
      .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .pool_en(b_pool_en), .pool_data(b_pool_data), .pool_result(b_pool_result),
      .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .dbg_state(b_dbg)
   );

   // Input SRAM read ports and signed running-max pooling units (max floors at 0).
   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= mem[a_rd_addr];
      if (b_rd_en) b_rd_data <= mem[b_rd_addr];
      if (!a_pool_en) a_pool_result <= '0;
      else if ($signed(a_pool_data) > $signed(a_pool_result)) a_pool_result <= a_pool_data;
      if (!b_pool_en) b_pool_result <= '0;
      else if ($signed(b_pool_data) > $signed(b_pool_result)) b_pool_result <= b_pool_data;
   end

   function automatic int rel();
      return cyc - s_cyc + 1;
   endfunction

   // Observed writes / done pulses from whichever instance is active.
   logic [AW-1:0] w_addr[$];
   logic [DW-1:0] w_data[$];
   int            w_t[$];
   int            d_t[$];
   logic [AW-1:0] b_last_rd = '0;

   always @(negedge clk) begin
      if (a_wr_en) begin w_addr.push_back(a_wr_addr); w_data.push_back(a_wr_data); w_t.push_back(rel()); end
      if (b_wr_en) begin w_addr.push_back(b_wr_addr); w_data.push_back(b_wr_data); w_t.push_back(rel()); end
      if (a_done || b_done) d_t.push_back(rel());
      if (b_rd_en) b_last_rd <= b_rd_addr;
   end

   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr_q[$];
   int            exp_t_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int t);
      exp_addr_q.push_back(addr);
      exp_q.push_back(data);
      exp_t_q.push_back(t);
   endtask

   task automatic clear_logs();
      w_addr.delete(); w_data.delete(); w_t.delete(); d_t.delete();
      exp_q.delete(); exp_addr_q.delete(); exp_t_q.delete();
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_wr_count"}, w_addr.size(), exp_q.size());
      n = (w_addr.size() < exp_q.size()) ? w_addr.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_wr%0d_addr", tag, i), 32'(w_addr[i]), 32'(exp_addr_q[i]));
         check($sformatf("%s_wr%0d_data", tag, i), w_data[i], exp_q[i]);
         check($sformatf("%s_wr%0d_time", tag, i), w_t[i], exp_t_q[i]);
      end
   endtask

   task automatic check_done(input string tag, input int cnt, input int t);
      check({tag, "_done_count"}, d_t.size(), cnt);
      if (d_t.size() > 0) check({tag, "_done_time"}, d_t[0], t);
   endtask

   task automatic kick(input bit sel, input logic [AW-1:0] ib, input logic [AW-1:0] ob);
      @(negedge clk);
      if (sel) begin b_start = 1'b1; b_in_base = ib; b_out_base = ob; end
      else begin a_start = 1'b1; a_in_base = ib; a_out_base = ob; end
      @(posedge clk);
      #1 s_cyc = cyc;
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic wait_rel(input int r);
      while (rel() < r) @(negedge clk);
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 16; i++) mem[i] = DW'(i);
   endtask

   task automatic exp_ramp_4x4();
      push_exp(12'h100, 32'd5, 6);
      push_exp(12'h101, 32'd7, 11);
      push_exp(12'h102, 32'd13, 16);
      push_exp(12'h103, 32'd15, 21);
   endtask

   function automatic logic [DW-1:0] win_max(input int base, input int w, input int r, input int c);
      logic signed [DW-1:0] m;
      logic [DW-1:0] v;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         v = mem[base + (2 * r + k / 2) * w + 2 * c + k % 2];
         if ($signed(v) > m) m = v;
      end
      return m;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_rd_en", a_rd_en, 0);
      check("rst_pool_en", a_pool_en, 0);
      check("rst_wr_en", a_wr_en, 0);
      check("rst_rd_addr", a_rd_addr, 0);
      check("rst_wr_addr", a_wr_addr, 0);
      check("rst_state", a_dbg, 0);
      rst = 1'b0;

      // 4x4 ramp map: maxima 5,7,13,15
      fill_ramp();
      clear_logs();
      exp_ramp_4x4();
      kick(1'b0, 12'h000, 12'h100);
      check("ramp_r1_rd_en", a_rd_en, 1);
      check("ramp_r1_rd_addr", a_rd_addr, 12'h000);
      check("ramp_r1_pool_en", a_pool_en, 0);
      check("ramp_r1_busy", a_busy, 1);
      wait_rel(2);
      check("ramp_r2_rd_addr", a_rd_addr, 12'h001);
      check("ramp_r2_pool_en", a_pool_en, 1);
      wait_rel(4);
      check("ramp_r4_rd_addr", a_rd_addr, 12'h005);
      wait_rel(5);
      check("ramp_r5_rd_en", a_rd_en, 0);
      check("ramp_r5_pool_data", a_pool_data, 32'd5);
      wait_rel(6);
      check("ramp_r6_rd_addr", a_rd_addr, 12'h002);
      check("ramp_r6_pool_en", a_pool_en, 0);
      wait_rel(21);
      check("ramp_flush_busy", a_busy, 1);
      check("ramp_flush_rd_en", a_rd_en, 0);
      check("ramp_flush_pool_en", a_pool_en, 0);
      wait_rel(22);
      check("ramp_done_busy", a_busy, 0);
      check("ramp_done", a_done, 1);
      wait_rel(30);
      compare_writes("ramp");
      check_done("ramp", 1, 22);

      // Signed windows: all-negative floors to 0, mixed gives 9
      mem[0] = DW'(-3); mem[1] = DW'(-7); mem[4] = DW'(-1); mem[5] = DW'(-9);
      mem[2] = DW'(4);  mem[3] = DW'(-2); mem[6] = DW'(9);  mem[7] = DW'(9);
      clear_logs();
      push_exp(12'h100, 32'd0, 6);
      push_exp(12'h101, 32'd9, 11);
      push_exp(12'h102, 32'd13, 16);
      push_exp(12'h103, 32'd15, 21);
      kick(1'b0, 12'h000, 12'h100);
      wait_rel(30);
      compare_writes("neg");
      check_done("neg", 1, 22);

      // start re-pulsed mid-run is ignored
      fill_ramp();
      clear_logs();
      exp_ramp_4x4();
      kick(1'b0, 12'h000, 12'h100);
      wait_rel(3);
      a_start = 1'b1;
      wait_rel(4);
      a_start = 1'b0;
      wait_rel(45);
      compare_writes("repulse");
      check_done("repulse", 1, 22);

      // Reset in the middle of a run
      clear_logs();
      push_exp(12'h100, 32'd5, 6);
      kick(1'b0, 12'h000, 12'h100);
      wait_rel(8);
      rst = 1'b1;
      wait_rel(9);
      rst = 1'b0;
      check("rstrun_rd_en", a_rd_en, 0);
      check("rstrun_pool_en", a_pool_en, 0);
      check("rstrun_wr_en", a_wr_en, 0);
      check("rstrun_busy", a_busy, 0);
      check("rstrun_state", a_dbg, 0);
      wait_rel(30);
      compare_writes("rstrun");
      check_done("rstrun", 0, 0);
      clear_logs();
      exp_ramp_4x4();
      kick(1'b0, 12'h000, 12'h100);
      wait_rel(30);
      compare_writes("rerun");
      check_done("rerun", 1, 22);

      // 8x8 map at 0x0F8
      for (int i = 0; i < 64; i++) mem[12'h0F8 + i] = DW'((i * 37) % 101 - 50);
      clear_logs();
      for (int wi = 0; wi < 16; wi++)
         push_exp(AW'(12'h200 + wi), win_max(12'h0F8, 8, wi / 4, wi % 4), 6 + 5 * wi);
      kick(1'b1, 12'h0F8, 12'h200);
      wait_rel(81);
      check("big_flush_busy", b_busy, 1);
      wait_rel(82);
      check("big_done", b_done, 1);
      check("big_done_busy", b_busy, 0);
      wait_rel(90);
      compare_writes("big");
      check_done("big", 1, 82);
      check("big_last_rd_addr", b_last_rd, 12'h137);

`ifdef POOL_CTRL_ABORT_EN
      fill_ramp();
      clear_logs();
      push_exp(12'h100, 32'd5, 6);
      kick(1'b0, 12'h000, 12'h100);
      wait_rel(7);
      a_abort = 1'b1;
      wait_rel(8);
      a_abort = 1'b0;
      check("abort_pulse", a_aborted, 1);
      check("abort_busy", a_busy, 0);
      check("abort_rd_en", a_rd_en, 0);
      check("abort_wr_en", a_wr_en, 0);
      wait_rel(9);
      check("abort_pulse_end", a_aborted, 0);
      wait_rel(30);
      compare_writes("abort");
      check_done("abort", 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
